// File: rtl/mem_access_stage.sv
// Memory-access stage: turns EX/MEM load/store requests into req/ack bus cycles and registers the WB value.
// Latency: 1 cycle pass-through when idle; a bus access takes at least 2 cycles (request edge + ack edge).
// Backpressure: stall_req holds the pipeline from access detection until the ack cycle. Optional MEM_ACCESS_TIMEOUT_EN adds bus_err.
module mem_access_stage #(
  parameter int ADDR_W = 30
`ifdef MEM_ACCESS_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_memWriteEnable,
  input  logic              mem_memReadEnable,
  input  logic [ADDR_W-1:0] mem_memAddr,
  input  logic [3:0]        mem_memSel,
  input  logic [31:0]       mem_result,
  input  logic [4:0]        mem_regDest,
  input  logic              mem_resultSel,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_sel,
  output logic [31:0]       dbus_wdata,
  input  logic              dbus_ack,
  input  logic [31:0]       dbus_rdata,
  output logic              stall_req,
  output logic [4:0]        wb_regDest,
  output logic [31:0]       wb_data,
  output logic              wb_writeEnable
`ifdef MEM_ACCESS_TIMEOUT_EN
  ,
  output logic              bus_err
`endif
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_access;
  logic                w_timeout;

  logic                r_dbus_req;
  logic                r_dbus_we;
  logic [ADDR_W-1:0]   r_dbus_addr;
  logic [3:0]          r_dbus_sel;
  logic [31:0]         r_dbus_wdata;
  logic [4:0]          r_wb_regDest;
  logic [31:0]         r_wb_data;
  logic                r_wb_writeEnable;

  // Store data is replicated across lanes so the bus slave can take any lane directly.
  function automatic logic [31:0] store_data(input logic [3:0] sel, input logic [31:0] res);
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: store_data = {4{res[7:0]}};
      4'b0011, 4'b1100:                   store_data = {2{res[15:0]}};
      default:                            store_data = res;
    endcase
  endfunction

  // Loads are right-aligned and zero-extended; irregular masks just keep the selected lanes in place.
  function automatic logic [31:0] load_data(input logic [3:0] sel, input logic [31:0] rd);
    case (sel)
      4'b1111: load_data = rd;
      4'b0011: load_data = {16'h0000, rd[15:0]};
      4'b1100: load_data = {16'h0000, rd[31:16]};
      4'b0001: load_data = {24'h000000, rd[7:0]};
      4'b0010: load_data = {24'h000000, rd[15:8]};
      4'b0100: load_data = {24'h000000, rd[23:16]};
      4'b1000: load_data = {24'h000000, rd[31:24]};
      default: load_data = rd & {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endcase
  endfunction

  assign w_access = mem_memWriteEnable | mem_memReadEnable;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_bus_err;

  // Counts BUSY cycles; held at zero in IDLE so each access starts from a fresh count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_BUSY) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  // An ack arriving on the last allowed cycle still wins over the timeout.
  assign w_timeout = (r_state == ST_BUSY) && !dbus_ack &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign bus_err   = r_bus_err;
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE launches on any enable, BUSY ends on ack (or timeout).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_access) w_state_nxt = ST_BUSY;
      ST_BUSY: if (dbus_ack || w_timeout) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: hold the pipeline from the cycle an access appears until the ack cycle.
  always_comb begin
    stall_req = 1'b0;
    case (r_state)
      ST_IDLE: stall_req = w_access;
      ST_BUSY: stall_req = !dbus_ack;
      default: stall_req = 1'b0;
    endcase
  end

  // Bus and write-back registers; bus fields stay frozen through BUSY so the slave sees a stable request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dbus_req       <= 1'b0;
      r_dbus_we        <= 1'b0;
      r_dbus_addr      <= '0;
      r_dbus_sel       <= 4'h0;
      r_dbus_wdata     <= 32'h0;
      r_wb_regDest     <= 5'd0;
      r_wb_data        <= 32'h0;
      r_wb_writeEnable <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      r_bus_err        <= 1'b0;
`endif
    end else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
      r_bus_err <= 1'b0;
`endif
      if (r_state == ST_IDLE) begin
        if (w_access) begin
          // Store wins when both enables are set.
          r_dbus_req       <= 1'b1;
          r_dbus_we        <= mem_memWriteEnable;
          r_dbus_addr      <= mem_memAddr;
          r_dbus_sel       <= mem_memSel;
          r_dbus_wdata     <= store_data(mem_memSel, mem_result);
          r_wb_writeEnable <= 1'b0;
        end else begin
          r_wb_regDest     <= mem_regDest;
          r_wb_data        <= mem_result;
          r_wb_writeEnable <= (mem_regDest != 5'd0) && !mem_resultSel;
        end
      end else begin
        if (dbus_ack) begin
          r_dbus_req   <= 1'b0;
          r_wb_regDest <= mem_regDest;
          if (r_dbus_we) begin
            r_wb_writeEnable <= 1'b0;
          end else begin
            r_wb_data        <= load_data(r_dbus_sel, dbus_rdata);
            r_wb_writeEnable <= (mem_regDest != 5'd0);
          end
        end else if (w_timeout) begin
          r_dbus_req       <= 1'b0;
          r_wb_writeEnable <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
          r_bus_err        <= 1'b1;
`endif
        end
      end
    end
  end

  assign dbus_req       = r_dbus_req;
  assign dbus_we        = r_dbus_we;
  assign dbus_addr      = r_dbus_addr;
  assign dbus_sel       = r_dbus_sel;
  assign dbus_wdata     = r_dbus_wdata;
  assign wb_regDest     = r_wb_regDest;
  assign wb_data        = r_wb_data;
  assign wb_writeEnable = r_wb_writeEnable;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, loads, stores, reset abort, idle ack, optional timeout.
// Inputs driven 1 time unit after the rising edge; outputs checked in the same window.
// Hand-computed expectations only.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        mem_memWriteEnable;
  logic        mem_memReadEnable;
  logic [29:0] mem_memAddr;
  logic [3:0]  mem_memSel;
  logic [31:0] mem_result;
  logic [4:0]  mem_regDest;
  logic        mem_resultSel;
  logic        dbus_req;
  logic        dbus_we;
  logic [29:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        stall_req;
  logic [4:0]  wb_regDest;
  logic [31:0] wb_data;
  logic        wb_writeEnable;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic        bus_err;
`endif

  int n_total = 0;
  int n_bad   = 0;

  mem_access_stage dut (
`ifdef MEM_ACCESS_TIMEOUT_EN
    .bus_err            (bus_err),
`endif
    .clk                (clk),
    .rst                (rst),
    .mem_memWriteEnable (mem_memWriteEnable),
    .mem_memReadEnable  (mem_memReadEnable),
    .mem_memAddr        (mem_memAddr),
    .mem_memSel         (mem_memSel),
    .mem_result         (mem_result),
    .mem_regDest        (mem_regDest),
    .mem_resultSel      (mem_resultSel),
    .dbus_req           (dbus_req),
    .dbus_we            (dbus_we),
    .dbus_addr          (dbus_addr),
    .dbus_sel           (dbus_sel),
    .dbus_wdata         (dbus_wdata),
    .dbus_ack           (dbus_ack),
    .dbus_rdata         (dbus_rdata),
    .stall_req          (stall_req),
    .wb_regDest         (wb_regDest),
    .wb_data            (wb_data),
    .wb_writeEnable     (wb_writeEnable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input logic [4:0] dest, input logic [31:0] res, input logic rsel);
    mem_memWriteEnable = 1'b0;
    mem_memReadEnable  = 1'b0;
    mem_regDest        = dest;
    mem_result         = res;
    mem_resultSel      = rsel;
  endtask

  // One complete access: request edge, 'waits' unacked BUSY cycles, then the ack edge.
  task automatic run_access(input string tag, input logic we, input logic re,
                            input logic [29:0] addr, input logic [3:0] sel,
                            input logic [31:0] res, input logic [4:0] dest, input int waits,
                            input logic [31:0] rdata, input logic [31:0] exp_wdata);
    mem_memWriteEnable = we;
    mem_memReadEnable  = re;
    mem_memAddr        = addr;
    mem_memSel         = sel;
    mem_result         = res;
    mem_regDest        = dest;
    mem_resultSel      = re & ~we;
    #1;
    chk({tag, ".stall_launch"}, stall_req, 1);
    step();
    chk({tag, ".req"}, dbus_req, 1);
    chk({tag, ".we"}, dbus_we, we);
    chk({tag, ".addr"}, dbus_addr, addr);
    chk({tag, ".sel"}, dbus_sel, sel);
    if (we) chk({tag, ".wdata"}, dbus_wdata, exp_wdata);
    chk({tag, ".wbwe_busy"}, wb_writeEnable, 0);
    for (int i = 0; i < waits; i++) begin
      chk({tag, ".stall_wait"}, stall_req, 1);
      step();
      chk({tag, ".req_hold"}, dbus_req, 1);
      chk({tag, ".addr_hold"}, dbus_addr, addr);
    end
    dbus_ack   = 1'b1;
    dbus_rdata = rdata;
    #1;
    chk({tag, ".stall_ack"}, stall_req, 0);
    step();
    dbus_ack           = 1'b0;
    mem_memWriteEnable = 1'b0;
    mem_memReadEnable  = 1'b0;
    chk({tag, ".req_done"}, dbus_req, 0);
  endtask

  initial begin
    rst = 1'b0;
    drive_idle(5'd0, 32'h0, 1'b0);
    mem_memAddr = '0;
    mem_memSel  = 4'h0;
    dbus_ack    = 1'b0;
    dbus_rdata  = 32'h0;
    #2;
    chk("rst.req", dbus_req, 0);
    chk("rst.wdata", dbus_wdata, 0);
    chk("rst.wb_data", wb_data, 0);
    chk("rst.wb_we", wb_writeEnable, 0);
    chk("rst.stall", stall_req, 0);
`ifdef MEM_ACCESS_TIMEOUT_EN
    chk("rst.bus_err", bus_err, 0);
`endif
    step();
    rst = 1'b1;

    // Pass-through variants
    drive_idle(5'd5, 32'hDEADBEEF, 1'b0);
    #1;
    chk("pt.stall", stall_req, 0);
    step();
    chk("pt.wb_we", wb_writeEnable, 1);
    chk("pt.wb_dest", wb_regDest, 5);
    chk("pt.wb_data", wb_data, 32'hDEADBEEF);
    chk("pt.stall2", stall_req, 0);
    drive_idle(5'd7, 32'h01020304, 1'b1);
    step();
    chk("pt_memsel.wb_we", wb_writeEnable, 0);
    chk("pt_memsel.wb_dest", wb_regDest, 7);
    drive_idle(5'd0, 32'h0BADF00D, 1'b0);
    step();
    chk("pt_r0.wb_we", wb_writeEnable, 0);
    chk("pt_r0.wb_data", wb_data, 32'h0BADF00D);

    // Loads: word with 3 wait states, then lane extraction cases
    run_access("ld_word", 0, 1, 30'h10, 4'b1111, 32'h0, 5'd3, 3, 32'h12345678, 32'h0);
    chk("ld_word.wb_data", wb_data, 32'h12345678);
    chk("ld_word.wb_we", wb_writeEnable, 1);
    chk("ld_word.wb_dest", wb_regDest, 3);
    run_access("ld_b2", 0, 1, 30'h11, 4'b0100, 32'h0, 5'd4, 1, 32'hAABBCCDD, 32'h0);
    chk("ld_b2.wb_data", wb_data, 32'h000000BB);
    run_access("ld_hhi", 0, 1, 30'h12, 4'b1100, 32'h0, 5'd4, 0, 32'hAABBCCDD, 32'h0);
    chk("ld_hhi.wb_data", wb_data, 32'h0000AABB);
    run_access("ld_hlo", 0, 1, 30'h13, 4'b0011, 32'h0, 5'd4, 0, 32'hAABBCCDD, 32'h0);
    chk("ld_hlo.wb_data", wb_data, 32'h0000CCDD);
    run_access("ld_b3", 0, 1, 30'h14, 4'b1000, 32'h0, 5'd4, 0, 32'hAABBCCDD, 32'h0);
    chk("ld_b3.wb_data", wb_data, 32'h000000AA);
    run_access("ld_mask", 0, 1, 30'h15, 4'b0101, 32'h0, 5'd4, 2, 32'hAABBCCDD, 32'h0);
    chk("ld_mask.wb_data", wb_data, 32'h00BB00DD);
    run_access("ld_sel0", 0, 1, 30'h16, 4'b0000, 32'h0, 5'd9, 0, 32'hAABBCCDD, 32'h0);
    chk("ld_sel0.wb_data", wb_data, 32'h0);
    chk("ld_sel0.wb_we", wb_writeEnable, 1);
    run_access("ld_r0", 0, 1, 30'h17, 4'b1111, 32'h0, 5'd0, 0, 32'h55555555, 32'h0);
    chk("ld_r0.wb_we", wb_writeEnable, 0);

    // Stores, including write priority when both enables are set
    run_access("st_b1", 1, 0, 30'h20, 4'b0010, 32'h000000EE, 5'd0, 2, 32'h0, 32'hEEEEEEEE);
    chk("st_b1.wb_we", wb_writeEnable, 0);
    run_access("st_h", 1, 0, 30'h21, 4'b1100, 32'h1234ABCD, 5'd0, 0, 32'h0, 32'hABCDABCD);
    chk("st_h.wb_we", wb_writeEnable, 0);
    run_access("st_both", 1, 1, 30'h22, 4'b1111, 32'hCAFEF00D, 5'd6, 1, 32'h99999999, 32'hCAFEF00D);
    chk("st_both.wb_we", wb_writeEnable, 0);

    // ack while idle must not disturb pass-through
    drive_idle(5'd6, 32'h00000011, 1'b0);
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hFFFFFFFF;
    #1;
    chk("idle_ack.stall", stall_req, 0);
    step();
    dbus_ack = 1'b0;
    chk("idle_ack.req", dbus_req, 0);
    chk("idle_ack.wb_data", wb_data, 32'h00000011);

    // Reset in the middle of BUSY, then a late ack
    mem_memReadEnable = 1'b1;
    mem_memAddr       = 30'h30;
    mem_memSel        = 4'b1111;
    mem_regDest       = 5'd8;
    step();
    chk("rstbusy.req_before", dbus_req, 1);
    rst = 1'b0;
    drive_idle(5'd0, 32'h00000055, 1'b0);
    #1;
    chk("rstbusy.req", dbus_req, 0);
    chk("rstbusy.stall", stall_req, 0);
    step();
    rst        = 1'b1;
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h77777777;
    step();
    dbus_ack = 1'b0;
    chk("rstbusy.late_req", dbus_req, 0);
    chk("rstbusy.late_stall", stall_req, 0);
    chk("rstbusy.late_wb_data", wb_data, 32'h00000055);
    chk("rstbusy.late_wb_we", wb_writeEnable, 0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Load never acked: 16 BUSY cycles, then bus_err pulse and release
    mem_memReadEnable = 1'b1;
    mem_memAddr       = 30'h40;
    mem_memSel        = 4'b1111;
    mem_regDest       = 5'd2;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("tmo.busy_err", bus_err, 0);
      chk("tmo.busy_stall", stall_req, 1);
      step();
    end
    drive_idle(5'd0, 32'h0, 1'b0);
    #1;
    chk("tmo.err", bus_err, 1);
    chk("tmo.req", dbus_req, 0);
    chk("tmo.stall", stall_req, 0);
    chk("tmo.wb_we", wb_writeEnable, 0);
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h33333333;
    step();
    dbus_ack = 1'b0;
    chk("tmo.err_pulse", bus_err, 0);
    chk("tmo.late_req", dbus_req, 0);
    chk("tmo.late_wb_data", wb_data, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
